// File: rtl/dror_pkg.sv
// -----------------------------------------------------------------------------
// dror_pkg
// Shared definitions for the LiDAR frame loader: FSM state encoding, the
// header-word layout constants used to hand a frame to the denoiser, and a
// small helper that turns a BRAM word index into a byte address.
// -----------------------------------------------------------------------------
package dror_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FLUSH,
        HDR_SIZE,
        HDR_GO,
        WAIT_DONE,
        DONE
    } state_t;

    // Word 0 of every BRAM is the control/header word.
    localparam logic [31:0] HDR_WORD   = 32'd0;
    // Value the denoiser leaves in Z word 0 when it has finished.
    localparam logic [31:0] DONE_MAGIC = 32'h0000_0FFF;
    // Value written to Y word 0 to kick off the denoiser.
    localparam logic [31:0] GO_FLAG    = 32'd1;

    // Points packed into one BRAM word (default BUS_SIZE / default N).
    localparam int DEF_N        = 16;
    localparam int DEF_BUS_SIZE = 32;
    localparam int LANES        = DEF_BUS_SIZE / DEF_N;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

    function automatic logic [31:0] word_to_byte(input logic [31:0] word, input int shift);
        return word << shift;
    endfunction

endpackage

// File: rtl/lidar_pair_packer.sv
// -----------------------------------------------------------------------------
// lidar_pair_packer
// Pair-packing datapath for the frame loader. Even points are parked in
// holding registers; when the odd partner arrives (or the frame is flushed)
// the packed word {upper lane, held even} and its byte address are presented
// combinationally for the loader FSM to register onto the BRAM port.
//
// Ports:
//   clock, reset     sole clock, synchronous active-high reset
//   clear            start of a new frame: clears holding regs and count
//   store            a point is accepted and kept this cycle
//   flush            force the upper lane to zero (trailing even point)
//   pt_x/pt_y/pt_z   incoming point coordinates
//   pair_x/y/z       packed write words
//   pair_addr        byte address of the word for the current pair
//   pending          an even point is held awaiting its partner
//   count            number of points stored in this frame
// -----------------------------------------------------------------------------
module lidar_pair_packer
    import dror_pkg::*;
#(
    parameter int N          = 16,
    parameter int BUS_SIZE   = 32,
    parameter int BRAM_SHIFT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                store,
    input  logic                flush,
    input  logic [N-1:0]        pt_x,
    input  logic [N-1:0]        pt_y,
    input  logic [N-1:0]        pt_z,
    output logic [BUS_SIZE-1:0] pair_x,
    output logic [BUS_SIZE-1:0] pair_y,
    output logic [BUS_SIZE-1:0] pair_z,
    output logic [31:0]         pair_addr,
    output logic                pending,
    output logic [N-1:0]        count
);

    logic [N-1:0] hold_x;
    logic [N-1:0] hold_y;
    logic [N-1:0] hold_z;
    logic [N-1:0] upper_x;
    logic [N-1:0] upper_y;
    logic [N-1:0] upper_z;

    // NOTE: reset is sampled inside the clocked block (synchronous), and all
    // state uses non-blocking assignments so every register updates together.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hold_x <= '0;
            hold_y <= '0;
            hold_z <= '0;
            count  <= '0;
        end else if (store) begin
            // An even index (count[0]==0) is parked; an odd one is consumed
            // directly from the inputs by the pair word below.
            if (!count[0]) begin
                hold_x <= pt_x;
                hold_y <= pt_y;
                hold_z <= pt_z;
            end
            count <= count + 1'b1;
        end
    end

    // With an odd count, an even point is parked awaiting its partner.
    assign pending = count[0];

    assign upper_x = flush ? '0 : pt_x;
    assign upper_y = flush ? '0 : pt_y;
    assign upper_z = flush ? '0 : pt_z;

    assign pair_x = BUS_SIZE'({upper_x, hold_x});
    assign pair_y = BUS_SIZE'({upper_y, hold_y});
    assign pair_z = BUS_SIZE'({upper_z, hold_z});

    // Point p lives at word 1 + p/2. For an odd p arriving, count==p; for a
    // flush after even p, count==p+1. Both give count>>1 == p/2.
    assign pair_addr = word_to_byte(32'd1 + 32'(count >> 1), BRAM_SHIFT);

endmodule

// File: rtl/lidar_frame_loader.sv
// -----------------------------------------------------------------------------
// lidar_frame_loader
// Streams a frame of LiDAR points into three BRAMs (X, Y, Z), two points per
// word starting at word 1, then writes the header (point count to X word 0,
// go flag to Y word 0) and polls Z word 0 until the denoiser reports done.
//
// Optional feature: define LOADER_TIMEOUT_EN to add a watchdog on the
// WAIT_DONE poll; without it timeout_err is tied low and the wait is unbounded.
//
// Ports:
//   clock, reset                 sole clock, synchronous active-high reset
//   start                        begin a frame (sampled in IDLE only)
//   pt_valid/pt_ready            point handshake
//   pt_x/pt_y/pt_z, pt_last      point coordinates, final-point marker
//   bram_addr, bram_en           shared byte address and enable
//   we_x/we_y/we_z               byte write enables
//   write_in_x/y/z               write data
//   read_out_z                   Z BRAM read data, 1-cycle latency
//   busy, frame_done             status: not-idle, one-cycle completion pulse
//   point_count                  points stored in the current frame
//   overflow, timeout_err        sticky per-frame error flags
// -----------------------------------------------------------------------------
module lidar_frame_loader
    import dror_pkg::*;
#(
    parameter int N              = 16,
    parameter int BUS_SIZE       = 32,
    parameter int BRAM_SHIFT     = 2,
    parameter int MAX_POINTS     = 4096,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                pt_valid,
    output logic                pt_ready,
    input  logic [N-1:0]        pt_x,
    input  logic [N-1:0]        pt_y,
    input  logic [N-1:0]        pt_z,
    input  logic                pt_last,
    output logic [31:0]         bram_addr,
    output logic                bram_en,
    output logic [3:0]          we_x,
    output logic [3:0]          we_y,
    output logic [3:0]          we_z,
    output logic [BUS_SIZE-1:0] write_in_x,
    output logic [BUS_SIZE-1:0] write_in_y,
    output logic [BUS_SIZE-1:0] write_in_z,
    input  logic [BUS_SIZE-1:0] read_out_z,
    output logic                busy,
    output logic                frame_done,
    output logic [N-1:0]        point_count,
    output logic                overflow,
    output logic                timeout_err
);

    if (BUS_SIZE != LANES * N) begin : g_bad_lanes
        $error("lidar_frame_loader: BUS_SIZE must hold exactly two N-bit points");
    end

    state_t              state;
    logic                rd_valid;
    logic                accept;
    logic                full;
    logic                store;
    logic                pend_next;
    logic                pk_clear;
    logic                pk_flush;
    logic                pending;
    logic [BUS_SIZE-1:0] pair_x;
    logic [BUS_SIZE-1:0] pair_y;
    logic [BUS_SIZE-1:0] pair_z;
    logic [31:0]         pair_addr;

    assign accept    = pt_valid && pt_ready;
    assign full      = (point_count == N'(MAX_POINTS));
    assign store     = accept && !full;
    // Whether an even point will still be parked once this handshake lands.
    assign pend_next = store ? !pending : pending;
    assign pk_clear  = (state == IDLE) && start;
    assign pk_flush  = (state == FLUSH);

    lidar_pair_packer #(
        .N          (N),
        .BUS_SIZE   (BUS_SIZE),
        .BRAM_SHIFT (BRAM_SHIFT)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pk_clear),
        .store     (store),
        .flush     (pk_flush),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .pt_z      (pt_z),
        .pair_x    (pair_x),
        .pair_y    (pair_y),
        .pair_z    (pair_z),
        .pair_addr (pair_addr),
        .pending   (pending),
        .count     (point_count)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pt_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            bram_en    <= 1'b0;
            bram_addr  <= '0;
            we_x       <= WE_NONE;
            we_y       <= WE_NONE;
            we_z       <= WE_NONE;
            write_in_x <= '0;
            write_in_y <= '0;
            write_in_z <= '0;
            rd_valid   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            // Bus is idle unless a state below drives a write or read.
            bram_en    <= 1'b0;
            bram_addr  <= '0;
            we_x       <= WE_NONE;
            we_y       <= WE_NONE;
            we_z       <= WE_NONE;
            write_in_x <= '0;
            write_in_y <= '0;
            write_in_z <= '0;
            frame_done <= 1'b0;
            // A pure read was on the port last cycle, so read_out_z is valid
            // now; guards against acting on stale data from before the poll.
            rd_valid   <= bram_en && (we_x == WE_NONE) && (we_y == WE_NONE) && (we_z == WE_NONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        pt_ready <= 1'b1;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else if (pending) begin
                            bram_en    <= 1'b1;
                            bram_addr  <= pair_addr;
                            we_x       <= WE_ALL;
                            we_y       <= WE_ALL;
                            we_z       <= WE_ALL;
                            write_in_x <= pair_x;
                            write_in_y <= pair_y;
                            write_in_z <= pair_z;
                        end
                        if (pt_last) begin
                            pt_ready <= 1'b0;
                            state    <= pend_next ? FLUSH : HDR_SIZE;
                        end
                    end
                end

                FLUSH: begin
                    // pair_* carry a zero upper lane while in FLUSH.
                    bram_en    <= 1'b1;
                    bram_addr  <= pair_addr;
                    we_x       <= WE_ALL;
                    we_y       <= WE_ALL;
                    we_z       <= WE_ALL;
                    write_in_x <= pair_x;
                    write_in_y <= pair_y;
                    write_in_z <= pair_z;
                    state      <= HDR_SIZE;
                end

                HDR_SIZE: begin
                    bram_en    <= 1'b1;
                    bram_addr  <= word_to_byte(HDR_WORD, BRAM_SHIFT);
                    we_x       <= WE_ALL;
                    we_y       <= WE_ALL;
                    we_z       <= WE_ALL;
                    write_in_x <= BUS_SIZE'(point_count);
                    state      <= HDR_GO;
                end

                HDR_GO: begin
                    bram_en    <= 1'b1;
                    bram_addr  <= word_to_byte(HDR_WORD, BRAM_SHIFT);
                    we_y       <= WE_ALL;
                    write_in_y <= BUS_SIZE'(GO_FLAG);
                    state      <= WAIT_DONE;
`ifdef LOADER_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end

                WAIT_DONE: begin
                    bram_en   <= 1'b1;
                    bram_addr <= word_to_byte(HDR_WORD, BRAM_SHIFT);
                    if (rd_valid && (read_out_z == BUS_SIZE'(DONE_MAGIC))) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        bram_en     <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    pt_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lidar_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_lidar_frame_loader
// Self-checking bench. A write monitor logs every BRAM write; each frame is
// checked by rebuilding BRAM contents from that log and comparing against the
// packing rules computed directly from the sent points.
// -----------------------------------------------------------------------------
module tb_lidar_frame_loader;

    localparam int          N     = 16;
    localparam int          BUS   = 32;
    localparam int          SHIFT = 2;
    localparam int          MAXP  = 4;
    localparam int          TOUT  = 100;
    localparam logic [31:0] MAGIC = 32'h0000_0FFF;
    localparam logic [31:0] SENT  = 32'hDEAD_BEEF;

    logic           clock;
    logic           reset;
    logic           start;
    logic           pt_valid;
    logic           pt_ready;
    logic [N-1:0]   pt_x;
    logic [N-1:0]   pt_y;
    logic [N-1:0]   pt_z;
    logic           pt_last;
    logic [31:0]    bram_addr;
    logic           bram_en;
    logic [3:0]     we_x;
    logic [3:0]     we_y;
    logic [3:0]     we_z;
    logic [BUS-1:0] write_in_x;
    logic [BUS-1:0] write_in_y;
    logic [BUS-1:0] write_in_z;
    logic [BUS-1:0] read_out_z;
    logic           busy;
    logic           frame_done;
    logic [N-1:0]   point_count;
    logic           overflow;
    logic           timeout_err;

    lidar_frame_loader #(
        .N              (N),
        .BUS_SIZE       (BUS),
        .BRAM_SHIFT     (SHIFT),
        .MAX_POINTS     (MAXP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_z        (pt_z),
        .pt_last     (pt_last),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .we_x        (we_x),
        .we_y        (we_y),
        .we_z        (we_z),
        .write_in_x  (write_in_x),
        .write_in_y  (write_in_y),
        .write_in_z  (write_in_z),
        .read_out_z  (read_out_z),
        .busy        (busy),
        .frame_done  (frame_done),
        .point_count (point_count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wx;
        logic [3:0]  wy;
        logic [3:0]  wz;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] dz;
    } wr_t;

    wr_t log_q[$];
    int  done_pulses = 0;

    always @(posedge clock) begin
        if (bram_en && (|we_x || |we_y || |we_z))
            log_q.push_back('{bram_addr, we_x, we_y, we_z, write_in_x, write_in_y, write_in_z});
        if (frame_done) done_pulses++;
    end

    int errors = 0;
    int checks = 0;
    logic [N-1:0] px [16];
    logic [N-1:0] py [16];
    logic [N-1:0] pz [16];

    function automatic int find_go(input int base);
        for (int k = base; k < log_q.size(); k++)
            if (log_q[k].addr == 32'd0 && log_q[k].wy == 4'hF && log_q[k].wx == 4'h0 && log_q[k].wz == 4'h0)
                return k;
        return -1;
    endfunction

    task automatic drive_idle;
        start = 0; pt_valid = 0; pt_last = 0; pt_x = '0; pt_y = '0; pt_z = '0;
    endtask

    task automatic rand_points(input int n);
        for (int i = 0; i < n; i++) begin
            px[i] = N'($urandom); py[i] = N'($urandom); pz[i] = N'($urandom);
        end
    endtask

    // Pulse start, wait for FILL, then stream n points (optionally with stray
    // start pulses, which must be ignored outside IDLE).
    task automatic send_points(input int n, input bit with_last, input bit stray);
        int c;
        start = 1; @(negedge clock); start = 0;
        c = 0;
        while (!pt_ready && c < 20) begin @(negedge clock); c++; end
        checks++;
        if (pt_ready !== 1'b1) begin errors++; $display("FAIL fill_entry: pt_ready=%b required 1", pt_ready); end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                pt_valid = 0; start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clock);
            end
            start = 0; pt_valid = 1;
            pt_x = px[i]; pt_y = py[i]; pt_z = pz[i];
            pt_last = with_last && (i == n - 1);
            @(negedge clock);
        end
        drive_idle;
    endtask

    task automatic wait_go(input int base, output int gi);
        gi = -1;
        for (int c = 0; c < 40 && gi < 0; c++) begin @(negedge clock); gi = find_go(base); end
        checks++;
        if (gi < 0) begin errors++; $display("FAIL go_write: not seen within 40 cycles, required one"); end
        checks++;
        if (busy !== 1'b1 || pt_ready !== 1'b0) begin
            errors++; $display("FAIL wait_status: busy=%b pt_ready=%b required 1/0", busy, pt_ready);
        end
    endtask

    task automatic finish_frame(input int base, input int done_base);
        int gi;
        bit seen;
        wait_go(base, gi);
        read_out_z = MAGIC;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin @(negedge clock); seen = frame_done; end
        checks++;
        if (!seen) begin errors++; $display("FAIL frame_done: not seen within 12 cycles"); end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: frame_done=%b busy=%b next cycle, required 0/0", frame_done, busy);
        end
        read_out_z = '0;
        checks++;
        if (done_pulses - done_base !== 1) begin
            errors++; $display("FAIL done_count: %0d pulses required 1", done_pulses - done_base);
        end
    endtask

    // Rebuild BRAM contents from the write log and compare to packing rules.
    task automatic verify_frame(input int n, input int base, input string tag);
        logic [31:0] mx [16];
        logic [31:0] my [16];
        logic [31:0] mz [16];
        int stored, nwords, data_writes, size_k, go_k, idx;
        logic [N-1:0] lo, hi;
        stored = (n < MAXP) ? n : MAXP;
        nwords = (stored + 1) / 2;
        data_writes = 0; size_k = -1; go_k = -1;
        for (int w = 0; w < 16; w++) begin mx[w] = SENT; my[w] = SENT; mz[w] = SENT; end
        for (int k = base; k < log_q.size(); k++) begin
            idx = int'(log_q[k].addr >> SHIFT);
            if (idx >= 16) begin
                checks++; errors++;
                $display("FAIL %s addr_range: addr %h outside model", tag, log_q[k].addr);
                continue;
            end
            for (int b = 0; b < 4; b++) begin
                if (log_q[k].wx[b]) mx[idx][8*b +: 8] = log_q[k].dx[8*b +: 8];
                if (log_q[k].wy[b]) my[idx][8*b +: 8] = log_q[k].dy[8*b +: 8];
                if (log_q[k].wz[b]) mz[idx][8*b +: 8] = log_q[k].dz[8*b +: 8];
            end
            if (idx != 0) data_writes++;
            if (idx == 0 && log_q[k].wx == 4'hF && size_k < 0) size_k = k;
            if (idx == 0 && log_q[k].wy == 4'hF && log_q[k].wx == 4'h0) go_k = k;
        end
        checks++;
        if (point_count !== 16'(stored)) begin errors++; $display("FAIL %s point_count: %0d required %0d", tag, point_count, stored); end
        checks++;
        if (overflow !== (n > MAXP)) begin errors++; $display("FAIL %s overflow: %b required %b", tag, overflow, n > MAXP); end
        checks++;
        if (mx[0] !== 32'(stored)) begin errors++; $display("FAIL %s hdr_size: x[0]=%h required %h", tag, mx[0], 32'(stored)); end
        checks++;
        if (my[0] !== 32'd1 || mz[0] !== 32'd0) begin errors++; $display("FAIL %s hdr_go: y[0]=%h z[0]=%h required 1/0", tag, my[0], mz[0]); end
        checks++;
        if (size_k < 0 || go_k <= size_k) begin errors++; $display("FAIL %s hdr_order: size at %0d go at %0d, size required first", tag, size_k, go_k); end
        checks++;
        if (data_writes !== nwords) begin errors++; $display("FAIL %s data_writes: %0d required %0d", tag, data_writes, nwords); end
        for (int w = 1; w <= nwords; w++) begin
            for (int a = 0; a < 3; a++) begin
                logic [31:0] got;
                lo = (a == 0) ? px[2*(w-1)] : (a == 1) ? py[2*(w-1)] : pz[2*(w-1)];
                hi = '0;
                if (2*(w-1) + 1 < stored) hi = (a == 0) ? px[2*w-1] : (a == 1) ? py[2*w-1] : pz[2*w-1];
                got = (a == 0) ? mx[w] : (a == 1) ? my[w] : mz[w];
                checks++;
                if (got !== {hi, lo}) begin
                    errors++; $display("FAIL %s word%0d lane_set%0d: %h required %h", tag, w, a, got, {hi, lo});
                end
            end
        end
        checks++;
        if (mx[nwords + 1] !== SENT) begin errors++; $display("FAIL %s past_end: x[%0d]=%h required untouched", tag, nwords + 1, mx[nwords + 1]); end
    endtask

    task automatic run_frame(input int n, input string tag, input bit stray);
        int base, db;
        base = log_q.size(); db = done_pulses;
        send_points(n, 1'b1, stray);
        finish_frame(base, db);
        verify_frame(n, base, tag);
    endtask

    task automatic test_reset;
        reset = 1; drive_idle; read_out_z = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, pt_ready, frame_done, bram_en, overflow, timeout_err} !== 6'b0) begin
            errors++; $display("FAIL reset_status: busy/ready/done/en/ovf/to=%b required 0", {busy, pt_ready, frame_done, bram_en, overflow, timeout_err});
        end
        checks++;
        if ({we_x, we_y, we_z} !== 12'h0 || bram_addr !== 32'd0) begin
            errors++; $display("FAIL reset_bus: we=%h addr=%h required 0", {we_x, we_y, we_z}, bram_addr);
        end
        checks++;
        if (point_count !== '0 || (write_in_x | write_in_y | write_in_z) !== '0) begin
            errors++; $display("FAIL reset_data: count=%0d required 0 with zero write data", point_count);
        end
        reset = 0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || pt_ready !== 1'b0) begin
            errors++; $display("FAIL idle_hold: busy=%b pt_ready=%b required 0/0 without start", busy, pt_ready);
        end
    endtask

    task automatic test_four_points;
        rand_points(4);
        for (int i = 0; i < 4; i++) px[i] = N'(i + 1);
        run_frame(4, "four_points", 1'b0);
    endtask

    task automatic test_three_points;
        rand_points(3);
        for (int i = 0; i < 3; i++) px[i] = N'(i + 1);
        run_frame(3, "three_points", 1'b0);
    endtask

    task automatic test_overflow;
        rand_points(6);
        run_frame(6, "overflow", 1'b0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 7);
            rand_points(n);
            run_frame(n, "random", 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        rand_points(2);
        run_frame(2, "b2b_a", 1'b0);
        rand_points(5);
        run_frame(5, "b2b_b", 1'b0);
    endtask

    task automatic test_reset_mid_fill;
        int snap;
        rand_points(3);
        send_points(3, 1'b0, 1'b0);
        reset = 1;
        @(negedge clock);
        checks++;
        if ({we_x, we_y, we_z} !== 12'h0 || pt_ready !== 1'b0 || busy !== 1'b0 || point_count !== '0) begin
            errors++; $display("FAIL reset_abort: we=%h ready=%b busy=%b count=%0d required all 0", {we_x, we_y, we_z}, pt_ready, busy, point_count);
        end
        snap = log_q.size();
        reset = 0;
        repeat (5) @(negedge clock);
        checks++;
        if (log_q.size() !== snap) begin errors++; $display("FAIL reset_no_write: %0d writes after reset required 0", log_q.size() - snap); end
        rand_points(2);
        run_frame(2, "after_reset", 1'b0);
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout;
        int base, db, gi, c;
        rand_points(2);
        base = log_q.size(); db = done_pulses;
        send_points(2, 1'b1, 1'b0);
        wait_go(base, gi);
        c = 0;
        while (timeout_err !== 1'b1 && c < 200) begin @(negedge clock); c++; end
        checks++;
        if (c < 95 || c > 105) begin errors++; $display("FAIL timeout_latency: %0d cycles required about %0d", c, TOUT); end
        checks++;
        if (done_pulses !== db || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_exit: done pulses %0d busy %b required 0/0", done_pulses - db, busy);
        end
        rand_points(2);
        run_frame(2, "after_timeout", 1'b0);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: %b required 0 after new start", timeout_err); end
    endtask
`else
    task automatic test_wait_forever;
        int base, db, gi;
        rand_points(2);
        base = log_q.size(); db = done_pulses;
        send_points(2, 1'b1, 1'b0);
        wait_go(base, gi);
        repeat (60) @(negedge clock);
        start = 1; @(negedge clock); start = 0;
        repeat (90) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || done_pulses !== db) begin
            errors++; $display("FAIL wait_forever: busy=%b to=%b pulses=%0d required 1/0/0", busy, timeout_err, done_pulses - db);
        end
        finish_frame(base, db);
        verify_frame(2, base, "wait_forever");
    endtask
`endif

    initial begin
        reset = 1; read_out_z = '0; drive_idle;
        test_reset;
        test_four_points;
        test_three_points;
        test_overflow;
        test_reset_mid_fill;
        test_back_to_back;
        test_random;
`ifdef LOADER_TIMEOUT_EN
        test_timeout;
`else
        test_wait_forever;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
